// File: rtl/psum_feedback_buffer.sv
// Partial-sum feedback store for the convolution accumulator: holds one word per output pixel
// across input-channel passes, selects bias vs. stored sum, and emits final sums.
module psum_feedback_buffer #(
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned IFM_SIZE_NEXT           = 10,
  parameter int unsigned IFM_DEPTH               = 3,
  parameter int unsigned ADDRESS_SIZE_NEXT_IFM   = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int unsigned NUMBER_OF_BITS_CHANNELS = $clog2(IFM_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             conv_valid,
  input  logic [DATA_WIDTH-1:0]            accu_data_in,
  output logic                             accu_enable,
  output logic [DATA_WIDTH-1:0]            data_in_from_next,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] out_addr,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned NumPix = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] LastPix = ADDRESS_SIZE_NEXT_IFM'(NumPix - 1);
  localparam logic [NUMBER_OF_BITS_CHANNELS-1:0] LastCh =
      NUMBER_OF_BITS_CHANNELS'(IFM_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                             state_q;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0]   pix_cnt_q;
  logic [NUMBER_OF_BITS_CHANNELS-1:0] ch_cnt_q;
  logic                               out_valid_q;
  logic [DATA_WIDTH-1:0]              out_data_q;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0]   out_addr_q;
  logic                               done_q;

  logic [DATA_WIDTH-1:0] mem [NumPix];

  logic accept;
  logic last_pix;
  logic last_ch;

  assign accept   = (state_q == StAccum) && conv_valid;
  assign last_pix = (pix_cnt_q == LastPix);
  assign last_ch  = (ch_cnt_q == LastCh);

  // No reset on the RAM: channel 0 always overwrites before any later pass reads.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[pix_cnt_q] <= accu_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StAccum;
            pix_cnt_q <= '0;
            ch_cnt_q  <= '0;
          end
        end
        StAccum: begin
          if (conv_valid) begin
            if (last_ch) begin
              out_valid_q <= 1'b1;
              out_data_q  <= accu_data_in;
              out_addr_q  <= pix_cnt_q;
            end
            if (last_pix) begin
              pix_cnt_q <= '0;
              if (last_ch) begin
                state_q <= StDone;
              end else begin
                ch_cnt_q <= ch_cnt_q + NUMBER_OF_BITS_CHANNELS'(1);
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + ADDRESS_SIZE_NEXT_IFM'(1);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Asynchronous read sees the pre-edge contents, i.e. the previous pass's value.
  assign busy              = (state_q == StAccum);
  assign accu_enable       = busy && (ch_cnt_q != '0);
  assign data_in_from_next = busy ? mem[pix_cnt_q] : '0;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_psum_feedback_buffer.sv
// Drives a depth-3 and a depth-1 instance with shared stimulus and checks each against a
// pixel-count based reference model.
module tb_psum_feedback_buffer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        conv_valid;
  logic [31:0] accu_data_in;

  logic        ae3, ov3, bz3, dn3, ae1, ov1, bz1, dn1;
  logic [31:0] dfn3, od3, dfn1, od1;
  logic [1:0]  oa3, oa1;

  always #5 clk = ~clk;

  psum_feedback_buffer #(
    .DATA_WIDTH   (32),
    .IFM_SIZE_NEXT(2),
    .IFM_DEPTH    (3)
  ) dut3 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .conv_valid       (conv_valid),
    .accu_data_in     (accu_data_in),
    .accu_enable      (ae3),
    .data_in_from_next(dfn3),
    .out_valid        (ov3),
    .out_data         (od3),
    .out_addr         (oa3),
    .busy             (bz3),
    .done             (dn3)
  );

  psum_feedback_buffer #(
    .DATA_WIDTH   (32),
    .IFM_SIZE_NEXT(2),
    .IFM_DEPTH    (1)
  ) dut1 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .conv_valid       (conv_valid),
    .accu_data_in     (accu_data_in),
    .accu_enable      (ae1),
    .data_in_from_next(dfn1),
    .out_valid        (ov1),
    .out_data         (od1),
    .out_addr         (oa1),
    .busy             (bz1),
    .done             (dn1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 accumulating, 2 done; k = pixels accepted in this map.
  int          dep   [2];
  int          ph    [2];
  int          k     [2];
  logic [31:0] store [2][N];
  logic        m_ov  [2];
  logic [31:0] m_od  [2];
  logic [31:0] m_oa  [2];
  logic        m_dn  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m]   = 0;
      k[m]    = 0;
      m_ov[m] = 1'b0;
      m_od[m] = '0;
      m_oa[m] = '0;
      m_dn[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input logic st, input logic cv, input logic [31:0] d);
    int pix;
    int ch;
    m_ov[m] = 1'b0;
    m_dn[m] = 1'b0;
    case (ph[m])
      0: if (st) begin
        ph[m] = 1;
        k[m]  = 0;
      end
      1: if (cv) begin
        pix = k[m] % N;
        ch  = k[m] / N;
        store[m][pix] = d;
        if (ch == dep[m] - 1) begin
          m_ov[m] = 1'b1;
          m_od[m] = d;
          m_oa[m] = 32'(pix);
        end
        k[m]++;
        if (k[m] == N * dep[m]) ph[m] = 2;
      end
      default: begin
        m_dn[m] = 1'b1;
        ph[m]   = 0;
      end
    endcase
  endtask

  task automatic check_dut(input int m, input logic ae, input logic [31:0] dfn, input logic ov,
                           input logic [31:0] od, input logic [1:0] oa, input logic bz,
                           input logic dn);
    logic accum;
    accum = (ph[m] == 1);
    check_eq($sformatf("d%0d busy", dep[m]), 32'(bz), 32'(accum));
    check_eq($sformatf("d%0d accu_enable", dep[m]), 32'(ae), 32'(accum && k[m] >= N));
    if (accum && k[m] >= N)
      check_eq($sformatf("d%0d data_in_from_next", dep[m]), dfn, store[m][k[m] % N]);
    else if (!accum)
      check_eq($sformatf("d%0d data_in_from_next idle", dep[m]), dfn, 32'd0);
    check_eq($sformatf("d%0d out_valid", dep[m]), 32'(ov), 32'(m_ov[m]));
    check_eq($sformatf("d%0d out_data", dep[m]), od, m_od[m]);
    check_eq($sformatf("d%0d out_addr", dep[m]), 32'(oa), m_oa[m]);
    check_eq($sformatf("d%0d done", dep[m]), 32'(dn), 32'(m_dn[m]));
  endtask

  task automatic cycle(input logic r, input logic st, input logic cv, input logic [31:0] d);
    @(negedge clk);
    reset        = r;
    start        = st;
    conv_valid   = cv;
    accu_data_in = d;
    #1;
    if (!r) model_reset();
    check_dut(0, ae3, dfn3, ov3, od3, oa3, bz3, dn3);
    check_dut(1, ae1, dfn1, ov1, od1, oa1, bz1, dn1);
    @(posedge clk);
    if (r) begin
      model_step(0, st, cv, d);
      model_step(1, st, cv, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, $urandom);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(10 * (i / 4) + i % 4 + 1);
  endfunction

  initial begin
    dep[0] = 3;
    dep[1] = 1;
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < N; p++) store[m][p] = '0;
    reset = 1'b0; start = 1'b0; conv_valid = 1'b0; accu_data_in = '0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);

    // Back-to-back map 1,2,3,4 / 11..14 / 21..24
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, pat(i));
    idle(4);

    // conv_valid toggling, junk data in gaps
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 24; i++)
      cycle(1'b1, 1'b0, (i % 2) == 0, (i % 2) == 0 ? pat(i / 2) : $urandom);
    idle(4);

    // conv_valid in idle, then start together with conv_valid
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'hdead_0000 + 32'(i));
    cycle(1'b1, 1'b1, 1'b1, 32'hbad0_0001);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, pat(i) + 32'd100);
    idle(4);

    // Reset mid-map, then a clean rerun
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 32'h5000 + 32'(i));
    cycle(1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    idle(2);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, pat(i));
    idle(4);

    // start held high for a whole map and beyond
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1, pat(i) + 32'd7);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    idle(2);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 200) != 0, ($urandom % 8) == 0, ($urandom % 4) != 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
